mem_access_unit: RTL
====================

# mem_access_unit

Core-side initiator for the single-ported synchronous data memory (DataMemory). It accepts byte/halfword/word load and store requests from the datapath and drives memRead/memWrite/addr/writeData. It returns sign- or zero-extended load data, and performs read-modify-write for sub-word stores, because the memory is word-wide with no byte enables. It sits between the execute/memory stage of the core and DataMemory; the core stalls while reqReady is low.

## Interface
- ADDR_WIDTH, 8, word-address width of DataMemory; byte address is ADDR_WIDTH+2 bits
- DATA_WIDTH, 32, memory word width; only 32 is supported (lane logic is fixed at 4 bytes)
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reqValid  in  1  core presents a request
- reqReady  out  1  high only in IDLE; request accepted on the edge where reqValid && reqReady
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- reqUnsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- reqAddr  in  ADDR_WIDTH+2  byte address, little-endian lanes
- reqWData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rspValid  out  1  one-cycle completion pulse
- rspRData  out  32  extended load data, valid with rspValid on loads, else 0
- rspError  out  1  misaligned request, valid with rspValid
- memRead  out  1  to DataMemory
- memWrite  out  1  to DataMemory
- memAddr  out  ADDR_WIDTH  word address = latched reqAddr[ADDR_WIDTH+1:2]
- memWData  out  32  to DataMemory writeData
- memRData  in  32  from DataMemory readData; valid the cycle after a memRead cycle

## Operation
- Accept in IDLE: latch write, size, unsigned, address and data.
- Next state after accept:
  - word store → STORE
  - load → READ
  - sub-word store → READ
  - misaligned request (macro on) → ERROR
- Moore FSM with five states plus ERROR:
  - IDLE: reqReady=1.
  - READ: memRead=1. Go to LOAD_RSP if the request is a load; go to MERGE_STORE if it is a sub-word store.
  - LOAD_RSP: rspValid=1. rspRData is the selected lane of memRData, extended. Go to IDLE.
  - STORE: memWrite=1, memWData=latched data, rspValid=1. Go to IDLE.
  - MERGE_STORE: memWrite=1, memWData = memRData with the target lane replaced, rspValid=1. Go to IDLE.
  - ERROR: rspValid=1, rspError=1, no memory strobes. Go to IDLE.
- Lane select:
  - byte: addr[1:0]=0..3 selects [7:0], [15:8], [23:16], [31:24]
  - half: addr[1]=0 selects [15:0]; addr[1]=1 selects [31:16]
- Extension: sign-extend from bit 7 (byte) or bit 15 (half) unless reqUnsigned is set. Word loads pass through unchanged.
- reqValid outside IDLE is ignored. The core holds its request until reqReady is high.
- memAddr stays at the last latched address in every state. memWData=0 outside STORE/MERGE_STORE.

## Timing
- Reset: state=IDLE; reqReady=1; all other outputs 0, including memAddr and the latched registers.
- memRead and memWrite are gated by !rst. A reset cycle never issues a memory command, even mid-operation.
- Latency, counted from the accept edge (cycle 0):
  - word store: memWrite and rspValid in cycle 1
  - load: memRead in cycle 1, rspValid in cycle 2
  - sub-word store: memRead in cycle 1, memWrite and rspValid in cycle 2
  - error: rspValid in cycle 1
- reqReady returns high in the cycle after the rspValid cycle. Throughput is one request per 2 cycles (word store, error) or per 3 cycles (all others).
- Reset during READ or MERGE_STORE aborts the access: no write, memory unchanged, IDLE on the next cycle.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - half with addr[0]=1, or word with addr[1:0]≠0, goes to ERROR
  - rspRData=0 on that response
- MEM_MISALIGN_CHECK_EN not defined:
  - no ERROR state; rspError tied 0
  - half ignores addr[0]; word ignores addr[1:0]; access proceeds normally

## Structure
- Package mem_access_pkg holds:
  - state enum (IDLE, READ, LOAD_RSP, STORE, MERGE_STORE, ERROR)
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD
- Sub-module mem_lane_unit (combinational) holds load lane extraction and extension, plus store lane merge. The FSM and latch registers stay in mem_access_unit.

## Test plan
- Reset: hold rst 2 cycles → reqReady=1, memRead=memWrite=rspValid=rspError=0, memAddr=0.
- Word round trip:
  - word store 0xDEADBEEF to 0x10 → cycle 1 has memWrite=1, memAddr=0x04, rspValid=1
  - word load from 0x10 → rspRData=0xDEADBEEF in cycle 2
- Byte store 0xAA to 0x11 over 0xDEADBEEF → memRead in cycle 1; memWrite in cycle 2 with memWData=0xDEADAAEF.
- Extended loads from word 0xDEADBEEF:
  - signed byte @0x13 → 0xFFFFFFDE
  - unsigned byte @0x13 → 0x000000DE
  - signed half @0x12 → 0xFFFFDEAD
  - unsigned half @0x10 → 0x0000BEEF
- Misaligned word load @0x12:
  - macro on → rspValid=rspError=1 in cycle 1, no strobes
  - macro off → memAddr=0x04, data 0xDEADBEEF
- rst asserted during MERGE_STORE → memWrite stays 0, a word reread returns the old value, reqReady=1 the next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit.
// FSM state encoding, access-size codes and the alignment helper.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD_RSP,
    STORE,
    MERGE_STORE,
    ERROR
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Size 2'b11 is treated as a word access.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = off[0];
      default:   m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic: load extraction/extension and sub-word store merge.
// Purely combinational; fixed 4-byte little-endian lanes.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ldata = rdata;
    unique case (size)
      SIZE_BYTE: ldata = {{24{b[7] & ~uns}}, b};
      SIZE_HALF: ldata = {{16{h[15] & ~uns}}, h};
      SIZE_WORD: ldata = rdata;
      default:   ldata = rdata;
    endcase
  end

  // Only sub-word stores reach the merge path; words pass rdata.
  always_comb begin
    mdata = rdata;
    unique case (size)
      SIZE_BYTE: begin
        unique case (off)
          2'd0: mdata[7:0]   = wdata[7:0];
          2'd1: mdata[15:8]  = wdata[7:0];
          2'd2: mdata[23:16] = wdata[7:0];
          2'd3: mdata[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) mdata[31:16] = wdata;
        else        mdata[15:0]  = wdata;
      end
      default: mdata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide DataMemory (RMW sub-word stores).
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word requests -> ERROR.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqUnsigned,
  input  logic [ADDR_WIDTH+1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqWData,
  output logic                  rspValid,
  output logic [DATA_WIDTH-1:0] rspRData,
  output logic                  rspError,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData
);

  state_t state, state_d;

  logic                  wr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic        accept;
  logic        mis;
  logic [31:0] ldata;
  logic [31:0] mdata;

  assign accept  = reqValid && (state == IDLE);
  assign memAddr = addr_q[ADDR_WIDTH+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis      = misaligned(reqSize, reqAddr[1:0]);
  assign rspError = (state == ERROR) && !rst;
`else
  assign mis      = 1'b0;
  assign rspError = 1'b0;
`endif

  mem_lane_unit u_lane (
    .size  (size_q),
    .uns   (uns_q),
    .off   (addr_q[1:0]),
    .rdata (memRData),
    .wdata (wdata_q[15:0]),
    .ldata (ldata),
    .mdata (mdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        wr_q    <= reqWrite;
        size_q  <= reqSize;
        uns_q   <= reqUnsigned;
        addr_q  <= reqAddr;
        wdata_q <= reqWData;
      end
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (reqValid) begin
          if (mis)
            state_d = ERROR;
          else if (reqWrite && reqSize[1])
            state_d = STORE;
          else
            state_d = READ;
        end
      end
      READ:        state_d = wr_q ? MERGE_STORE : LOAD_RSP;
      LOAD_RSP:    state_d = IDLE;
      STORE:       state_d = IDLE;
      MERGE_STORE: state_d = IDLE;
      ERROR:       state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Strobes and responses are masked by rst so a reset cycle is inert.
  always_comb begin
    reqReady = (state == IDLE);
    memRead  = 1'b0;
    memWrite = 1'b0;
    memWData = '0;
    rspValid = 1'b0;
    rspRData = '0;
    unique case (state)
      READ: memRead = !rst;
      LOAD_RSP: begin
        rspValid = !rst;
        rspRData = ldata;
      end
      STORE: begin
        memWrite = !rst;
        memWData = wdata_q;
        rspValid = !rst;
      end
      MERGE_STORE: begin
        memWrite = !rst;
        memWData = mdata;
        rspValid = !rst;
      end
      ERROR:   rspValid = !rst;
      default: ;
    endcase
  end

endmodule
